// File: rtl/pacman_soc_usb_irq_ctrl.sv
// Purpose: conditions the MAX3421E INT/GPX pins and turns them into sticky, maskable edge flags and an IRQ.
// Latency: a pin change reaches the filtered level 2+FILTER_CYCLES edges later, the flag one edge after that, irq one more.
// Backpressure: none; reads return on the next edge and writes always complete.
module pacman_soc_usb_irq_ctrl #(
   parameter int FILTER_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        usb_int,
   input  logic        usb_gpx,
   output logic        irq
);

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   // bit0 = usb_int, bit1 = usb_gpx throughout
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_filt;
   logic [1:0]       r_filt_q;
   logic [CNT_W-1:0] r_cnt [2];
   logic [1:0]       r_edge_sel;
   logic [1:0]       r_mask;
   logic [1:0]       r_cap;
   logic             r_irq;
   logic [31:0]      r_readdata;

   logic [1:0]       w_pins;
   logic [1:0]       w_rise;
   logic [1:0]       w_fall;
   logic [1:0]       w_sel_edge;
   logic [1:0]       w_clr;

   assign w_pins     = {usb_gpx, usb_int};
   assign w_rise     = r_filt & ~r_filt_q;
   assign w_fall     = ~r_filt & r_filt_q;
   assign w_sel_edge = (r_edge_sel & w_fall) | (~r_edge_sel & w_rise);
   assign w_clr      = (write && address == ADDR_EDGE_CAP) ? writedata[1:0] : 2'b00;

   assign readdata = r_readdata;
   assign irq      = r_irq;

   // two-flop synchroniser on the asynchronous pins
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
      end else begin
         r_sync1 <= w_pins;
         r_sync2 <= r_sync1;
      end
   end

   // glitch filter: the level flips only after FILTER_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         r_filt   <= 2'b00;
         r_filt_q <= 2'b00;
         r_cnt[0] <= '0;
         r_cnt[1] <= '0;
      end else begin
         r_filt_q <= r_filt;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_filt[i] <= r_sync2[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // control registers, sticky edge flags (set beats a same-cycle clear) and registered irq
   always_ff @(posedge clk) begin
      if (reset) begin
         r_edge_sel <= 2'b00;
         r_mask     <= 2'b00;
         r_cap      <= 2'b00;
         r_irq      <= 1'b0;
      end else begin
         if (write && address == ADDR_EDGE_SEL) r_edge_sel <= writedata[1:0];
         if (write && address == ADDR_IRQ_MASK) r_mask     <= writedata[1:0];
         r_cap <= (r_cap & ~w_clr) | w_sel_edge;
         r_irq <= |(r_cap & r_mask);
      end
   end

   // read data sampled from pre-edge register state; held while read is low
   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= 32'd0;
      end else if (read) begin
         case (address)
            ADDR_DATA:     r_readdata <= {30'd0, r_filt};
            ADDR_EDGE_SEL: r_readdata <= {30'd0, r_edge_sel};
            ADDR_IRQ_MASK: r_readdata <= {30'd0, r_mask};
            default:       r_readdata <= {30'd0, r_cap};
         endcase
      end
   end

endmodule

// File: tb/tb_pacman_soc_usb_irq_ctrl.sv
// Directed bench for the USB interrupt conditioner: filtering, edge capture, W1C, masking and reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// FILTER_CYCLES = 4, so a pin change after edge 0 reaches filt at edge 6, cap at edge 7, irq at edge 8.
module tb_pacman_soc_usb_irq_ctrl;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        usb_int;
   logic        usb_gpx;
   logic        irq;

   int n_cmp;
   int n_err;

   pacman_soc_usb_irq_ctrl #(.FILTER_CYCLES(4), .CNT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .usb_int   (usb_int),
      .usb_gpx   (usb_gpx),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      tick(1);
      write     = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      read    = 1'b1;
      tick(1);
      read    = 1'b0;
      chk(tag, readdata, exp);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b1;
      address   = 2'd0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = 32'd0;
      usb_int   = 1'b0;
      usb_gpx   = 1'b0;
      tick(3);
      reset = 1'b0;

      // reset state
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_rdata", readdata, 32'd0);
      rd_chk("rst_edge_sel", 2'd1, 32'd0);
      rd_chk("rst_mask", 2'd2, 32'd0);
      rd_chk("rst_cap", 2'd3, 32'd0);

      // 1: usb_int rises with mask=0; DATA visible one read after filt flips at edge 6
      usb_int = 1'b1;
      address = 2'd0;
      read    = 1'b1;
      tick(6);
      chk("t1_data_e6", readdata, 32'd0);
      tick(1);
      chk("t1_data_e7", readdata, 32'h1);
      read = 1'b0;
      rd_chk("t1_cap", 2'd3, 32'h1);
      chk("t1_irq_masked", {31'd0, irq}, 32'd0);
      rd_chk("t1_cap_not_cleared_by_read", 2'd3, 32'h1);
      wr(2'd3, 32'h1);
      rd_chk("t1_cap_w1c", 2'd3, 32'h0);

      // 2: 3-cycle glitch on gpx is rejected, a sustained high passes
      usb_gpx = 1'b1;
      tick(3);
      usb_gpx = 1'b0;
      tick(8);
      rd_chk("t2_glitch_data", 2'd0, 32'h1);
      rd_chk("t2_glitch_cap", 2'd3, 32'h0);
      usb_gpx = 1'b1;
      tick(8);
      rd_chk("t2_data", 2'd0, 32'h3);
      rd_chk("t2_cap", 2'd3, 32'h2);
      wr(2'd3, 32'h3);

      // 3: falling-edge capture on gpx, irq timing after the fall
      usb_gpx = 1'b0;
      tick(8);
      wr(2'd1, 32'h2);
      wr(2'd2, 32'h3);
      usb_gpx = 1'b1;
      tick(8);
      rd_chk("t3_rise_ignored", 2'd3, 32'h0);
      chk("t3_irq_idle", {31'd0, irq}, 32'd0);
      usb_gpx = 1'b0;
      tick(7);
      chk("t3_irq_e7", {31'd0, irq}, 32'd0);
      tick(1);
      chk("t3_irq_e8", {31'd0, irq}, 32'd1);
      rd_chk("t3_cap", 2'd3, 32'h2);

      // 4: partial then full W1C
      usb_int = 1'b0;
      tick(8);
      usb_int = 1'b1;
      tick(8);
      rd_chk("t4_cap3", 2'd3, 32'h3);
      chk("t4_irq_on", {31'd0, irq}, 32'd1);
      wr(2'd3, 32'h1);
      tick(1);
      chk("t4_irq_still", {31'd0, irq}, 32'd1);
      rd_chk("t4_cap2", 2'd3, 32'h2);
      wr(2'd3, 32'h2);
      chk("t4_irq_lag", {31'd0, irq}, 32'd1);
      tick(1);
      chk("t4_irq_off", {31'd0, irq}, 32'd0);
      rd_chk("t4_cap0", 2'd3, 32'h0);

      // 5: clear of bit0 in the same cycle its rising edge is captured; set wins
      usb_int = 1'b0;
      tick(8);
      usb_int = 1'b1;
      tick(6);
      address   = 2'd3;
      writedata = 32'h1;
      write     = 1'b1;
      tick(1);
      write     = 1'b0;
      rd_chk("t5_set_wins", 2'd3, 32'h1);
      tick(1);
      chk("t5_irq", {31'd0, irq}, 32'd1);
      wr(2'd2, 32'h0);
      chk("t5_mask_lag", {31'd0, irq}, 32'd1);
      tick(1);
      chk("t5_mask_off", {31'd0, irq}, 32'd0);
      rd_chk("t5_cap_kept", 2'd3, 32'h1);
      wr(2'd2, 32'h1);
      tick(1);
      chk("t5_mask_reenable", {31'd0, irq}, 32'd1);

      // read and write in one cycle returns the old value; upper bits ignored
      address   = 2'd1;
      writedata = 32'hFFFF_FFF1;
      read      = 1'b1;
      write     = 1'b1;
      tick(1);
      read      = 1'b0;
      write     = 1'b0;
      chk("rw_old_value", readdata, 32'h2);
      rd_chk("rw_new_value", 2'd1, 32'h1);
      wr(2'd1, 32'h2);
      wr(2'd0, 32'h3);
      rd_chk("data_ro", 2'd0, 32'h1);

      // 6: reset during a partial gpx count with cap=0x3
      usb_gpx = 1'b1;
      tick(8);
      usb_gpx = 1'b0;
      tick(8);
      rd_chk("t6_cap_pre", 2'd3, 32'h3);
      usb_gpx = 1'b1;
      tick(4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t6_irq_rst", {31'd0, irq}, 32'd0);
      chk("t6_rdata_rst", readdata, 32'd0);
      rd_chk("t6_cap_rst", 2'd3, 32'h0);
      rd_chk("t6_mask_rst", 2'd2, 32'h0);
      rd_chk("t6_sel_rst", 2'd1, 32'h0);
      address = 2'd0;
      read    = 1'b1;
      tick(3);
      chk("t6_data_r6", readdata, 32'h0);
      tick(1);
      chk("t6_data_r7", readdata, 32'h3);
      read = 1'b0;
      rd_chk("t6_rise_after_rst", 2'd3, 32'h3);
      chk("t6_irq_masked", {31'd0, irq}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
